// File: rtl/l2_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and defaults for the L2 request arbiter.
//   state_t  : arbiter FSM states (IDLE / BUSY / DRAIN)
//   l2_cmd_t : command latched from the winning requester
//   rr_next  : round-robin successor of an index modulo n
// ---------------------------------------------------------------------------
package l2_arb_pkg;

  localparam int L2_ADDR_W      = 32;
  localparam int L2_DATA_W      = 128;
  localparam int L2_ARB_NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The command is stored at the package widths; instances must not use
  // wider ADDR_W / DATA_W than these.
  typedef struct packed {
    logic                 we;
    logic [L2_ADDR_W-1:0] addr;
    logic [L2_DATA_W-1:0] wdata;
  } l2_cmd_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/l2_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_req_arbiter_if
// Bundles the requester side and the L2 side of the arbiter.
//   master : arbiter view (samples requests / L2 responses, drives grants,
//            completions and the L2 command lines)
//   slave  : environment view (requesters plus the L2 cache)
// ---------------------------------------------------------------------------
interface l2_req_arbiter_if
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ = L2_ARB_NUM_REQ,
  parameter int ADDR_W  = L2_ADDR_W,
  parameter int DATA_W  = L2_DATA_W
) ();

  // requester side
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      busy;

  // L2 side
  logic                      l2_read_req;
  logic                      l2_write_req;
  logic                      l2_write_signal;
  logic [ADDR_W-1:0]         l2_addr;
  logic [DATA_W-1:0]         l2_write_data;
  logic                      l2_written;
  logic                      l2_ready;
  logic [DATA_W-1:0]         l2_read_data;

  modport master (
    input  req, req_we, req_addr, req_wdata, l2_ready, l2_read_data,
    output gnt, done, err, rsp_rdata, busy,
           l2_read_req, l2_write_req, l2_write_signal, l2_addr,
           l2_write_data, l2_written
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, l2_ready, l2_read_data,
    input  gnt, done, err, rsp_rdata, busy,
           l2_read_req, l2_write_req, l2_write_signal, l2_addr,
           l2_write_data, l2_written
  );

endinterface

// File: rtl/l2_req_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set bit of req_i scanning
// ptr_i, ptr_i+1, ... modulo NUM_REQ.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   gnt_o   : one-hot winner
//   idx_o   : winner index
//   valid_o : any request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int               c;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to ptr itself so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cand = IDX_W'(c);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_req_arbiter.sv
// ---------------------------------------------------------------------------
// l2_req_arbiter
// Shares a single-ported L2 between NUM_REQ requesters, round-robin.
//   clk, rst : clock and synchronous active-high reset
//   bus_io   : l2_req_arbiter_if.master (requester and L2 handshakes)
// Flow: IDLE picks a winner and latches its command; BUSY holds the L2
// request lines until l2_ready (or watchdog expiry), then pulses done/err
// and l2_written; DRAIN waits for the L2 to drop l2_ready.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_REQ     = L2_ARB_NUM_REQ,
  parameter int ADDR_W      = L2_ADDR_W,
  parameter int DATA_W      = L2_DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst,
  l2_req_arbiter_if.master   bus_io
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC - 1);

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     win_q;
  logic [WD_W-1:0]      wd_q;
  l2_cmd_t              cmd_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q, err_q;
  logic [DATA_W-1:0]    rsp_q;
  logic                 busy_q, rd_req_q, wr_req_q, wr_sig_q, written_q;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_valid;

  logic [ADDR_W-1:0]    addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]    wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus_io.req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = bus_io.req_wdata[gi*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i   (bus_io.req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  // Priority moves to the requester just after the one being served.
  always_comb begin
    ptr_d = IDX_W'(rr_next(32'(win_q), NUM_REQ));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      wd_q      <= '0;
      cmd_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rsp_q     <= '0;
      busy_q    <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_sig_q  <= 1'b0;
      written_q <= 1'b0;
    end else begin
      // done, err and l2_written are single-cycle pulses
      done_q    <= '0;
      err_q     <= '0;
      written_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            cmd_q.we    <= bus_io.req_we[pick_idx];
            cmd_q.addr  <= L2_ADDR_W'(addr_arr[pick_idx]);
            cmd_q.wdata <= L2_DATA_W'(wdata_arr[pick_idx]);
            win_q       <= pick_idx;
            gnt_q       <= pick_gnt;
            rd_req_q    <= ~bus_io.req_we[pick_idx];
            wr_req_q    <= bus_io.req_we[pick_idx];
            wr_sig_q    <= bus_io.req_we[pick_idx];
            busy_q      <= 1'b1;
            wd_q        <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // l2_ready takes precedence over a watchdog expiry in the same cycle
          if (bus_io.l2_ready || (wd_q == WD_MAX)) begin
            done_q <= gnt_q;
            err_q  <= bus_io.l2_ready ? '0 : gnt_q;
            if (!bus_io.l2_ready) begin
              rsp_q <= '0;
            end else if (!cmd_q.we) begin
              rsp_q <= bus_io.l2_read_data;
            end
            written_q <= 1'b1;
            gnt_q     <= '0;
            rd_req_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_sig_q  <= 1'b0;
            cmd_q     <= '0;
            wd_q      <= '0;
            ptr_q     <= ptr_d;
            state_q   <= DRAIN;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        DRAIN: begin
          if (!bus_io.l2_ready) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_io.gnt             = gnt_q;
  assign bus_io.done            = done_q;
  assign bus_io.err             = err_q;
  assign bus_io.rsp_rdata       = rsp_q;
  assign bus_io.busy            = busy_q;
  assign bus_io.l2_read_req     = rd_req_q;
  assign bus_io.l2_write_req    = wr_req_q;
  assign bus_io.l2_write_signal = wr_sig_q;
  assign bus_io.l2_addr         = ADDR_W'(cmd_q.addr);
  assign bus_io.l2_write_data   = DATA_W'(cmd_q.wdata);
  assign bus_io.l2_written      = written_q;

endmodule
